// File: rtl/distance_pkg.sv
// Shared types and defaults for the proximity detector: FSM states, distance width
// and the tick/threshold/confirm defaults.
package distance_pkg;

   typedef enum logic [1:0] {FAR, NEAR_PEND, NEAR, FAR_PEND} prox_state_e;

   localparam int DIST_W            = 20;
   localparam int TICK_W            = 24;
   localparam int SAMPLE_CYCLES_DEF = 4194304;
   localparam int NEAR_TH_DEF       = 20;
   localparam int FAR_TH_DEF        = 30;
   localparam int CONFIRM_DEF       = 3;

endpackage

// File: rtl/distance_proximity_if.sv
// Bundle between the ranging-stage consumer and its user: raw distance in,
// smoothed average, update pulse and debounced near flag out.
interface distance_proximity_if import distance_pkg::*; #(
   parameter int W = DIST_W
) ();

   logic [W-1:0] distance;
   logic [W-1:0] avg_distance;
   logic         sample_valid;
   logic         near;

   modport master (output distance, input avg_distance, input sample_valid, input near);
   modport slave  (input distance, output avg_distance, output sample_valid, output near);

endinterface

// File: rtl/dist_avg4.sv
// Zero-rejecting 4-deep moving average with a running sum; pulses valid_o
// whenever a full-window average is published.
module dist_avg4 import distance_pkg::*; #(
   parameter int W = DIST_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         take_i,
   input  logic [W-1:0] dist_i,
   output logic [W-1:0] avg_o,
   output logic         valid_o
);

   function automatic logic [W-1:0] div4_trunc(input logic [W+1:0] s);
      return s[W+1:2];
   endfunction

   logic [3:0][W-1:0] win_p1_q;
   logic [2:0]        fill_p1_q, fill_d;
   logic [W+1:0]      sum_p1_q, sum_d;
   logic [W-1:0]      avg_p1_q;
   logic              vld_p1_q;
   logic              accept;
   logic              full_d;

   always_comb begin
      accept = take_i && (dist_i != '0);
      sum_d  = sum_p1_q + {2'b00, dist_i} - {2'b00, win_p1_q[3]};
      fill_d = (fill_p1_q == 3'd4) ? fill_p1_q : fill_p1_q + 3'd1;
      full_d = (fill_d == 3'd4);
   end

   // stage p1: window, running sum and published average
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_p1_q  <= '0;
         fill_p1_q <= '0;
         sum_p1_q  <= '0;
         avg_p1_q  <= '0;
         vld_p1_q  <= 1'b0;
      end else begin
         vld_p1_q <= accept && full_d;
         if (accept) begin
            win_p1_q  <= {win_p1_q[2:0], dist_i};
            sum_p1_q  <= sum_d;
            fill_p1_q <= fill_d;
            if (full_d) avg_p1_q <= div4_trunc(sum_d);
         end
      end
   end

   assign avg_o   = avg_p1_q;
   assign valid_o = vld_p1_q;

endmodule

// File: rtl/distance_proximity.sv
// Samples the free-running distance word on a fixed tick, averages accepted
// samples and debounces the result into a near flag with confirmed hysteresis.
module distance_proximity import distance_pkg::*; #(
   parameter int W             = DIST_W,
   parameter int SAMPLE_CYCLES = SAMPLE_CYCLES_DEF,
   parameter int NEAR_TH       = NEAR_TH_DEF,
   parameter int FAR_TH        = FAR_TH_DEF,
   parameter int CONFIRM       = CONFIRM_DEF
) (
   input logic                 clk,
   input logic                 rst_n,
   distance_proximity_if.slave prox
);

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_CYCLES - 1);
   localparam logic [W-1:0]      NEAR_TH_W = W'(NEAR_TH);
   localparam logic [W-1:0]      FAR_TH_W  = W'(FAR_TH);
   localparam logic [3:0]        CONFIRM_C = 4'(CONFIRM);

   logic [1:0]        rst_sync_q;
   logic              rst_int_n;
   logic [TICK_W-1:0] tick_cnt_q;
   logic              tick;
   logic [W-1:0]      dist_p0_q;
   logic              vld_p0_q;
   logic [W-1:0]      avg;
   logic              avg_vld;
   prox_state_e       state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [3:0]        cnt_inc;
   logic              near_vote, far_vote;

   // Assertion is immediate; release is retimed through two flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= '0;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_int_n = rst_sync_q[1];

   assign tick = (tick_cnt_q == TICK_LAST);

   // stage p0: tick counter and distance capture
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         tick_cnt_q <= '0;
         dist_p0_q  <= '0;
         vld_p0_q   <= 1'b0;
      end else begin
         tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
         vld_p0_q   <= tick;
         if (tick) dist_p0_q <= prox.distance;
      end
   end

   dist_avg4 #(.W(W)) u_avg (
      .clk     (clk),
      .rst_n   (rst_int_n),
      .take_i  (vld_p0_q),
      .dist_i  (dist_p0_q),
      .avg_o   (avg),
      .valid_o (avg_vld)
   );

   // stage p2: hysteresis FSM
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q <= FAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cnt_inc   = cnt_q + 4'd1;
      near_vote = (avg < NEAR_TH_W);
      far_vote  = (avg > FAR_TH_W);
      if (avg_vld) begin
         unique case (state_q)
            FAR: if (near_vote) begin
               state_d = (CONFIRM_C == 4'd1) ? NEAR : NEAR_PEND;
               cnt_d   = (CONFIRM_C == 4'd1) ? 4'd0 : 4'd1;
            end
            NEAR_PEND: begin
               if (!near_vote) begin
                  state_d = FAR;
                  cnt_d   = '0;
               end else if (cnt_inc == CONFIRM_C) begin
                  state_d = NEAR;
                  cnt_d   = '0;
               end else cnt_d = cnt_inc;
            end
            NEAR: if (far_vote) begin
               state_d = (CONFIRM_C == 4'd1) ? FAR : FAR_PEND;
               cnt_d   = (CONFIRM_C == 4'd1) ? 4'd0 : 4'd1;
            end
            FAR_PEND: begin
               if (!far_vote) begin
                  state_d = NEAR;
                  cnt_d   = '0;
               end else if (cnt_inc == CONFIRM_C) begin
                  state_d = FAR;
                  cnt_d   = '0;
               end else cnt_d = cnt_inc;
            end
            default: begin
               state_d = FAR;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign prox.avg_distance = avg;
   assign prox.sample_valid = avg_vld;
   assign prox.near         = (state_q == NEAR) || (state_q == FAR_PEND);

endmodule

// File: tb/tb_distance_proximity.sv
// Directed bench for distance_proximity with a 16-cycle sample tick.
module tb_distance_proximity;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   distance_proximity_if #(.W(20)) prox ();

   distance_proximity #(
      .W(20), .SAMPLE_CYCLES(16), .NEAR_TH(20), .FAR_TH(30), .CONFIRM(3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .prox  (prox)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_pulse(input int maxc, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (prox.sample_valid !== 1'b1 && n < maxc);
   endtask

   // Waits for the next average pulse, checks latency, value and the near flag
   // on the pulse cycle and on the cycle after it.
   task automatic pulse(input string tag, input int exp_n, input int exp_avg,
                        input logic near_before, input logic near_after);
      int n;
      wait_pulse(exp_n + 20, n);
      check({tag, "_lat"}, n, exp_n);
      check({tag, "_avg"}, prox.avg_distance, exp_avg);
      check({tag, "_near_at"}, {31'd0, prox.near}, {31'd0, near_before});
      @(negedge clk);
      check({tag, "_vld_off"}, {31'd0, prox.sample_valid}, 32'd0);
      check({tag, "_near_next"}, {31'd0, prox.near}, {31'd0, near_after});
   endtask

   initial begin
      int seen;
      rst_n         = 1'b1;
      prox.distance = 20'd100;
      #2 rst_n = 1'b0;
      #1;
      check("rst_avg", prox.avg_distance, 0);
      check("rst_vld", {31'd0, prox.sample_valid}, 0);
      check("rst_near", {31'd0, prox.near}, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      pulse("first", 67, 100, 1'b0, 1'b0);

      prox.distance = 20'd10;
      pulse("dn77", 15, 77, 1'b0, 1'b0);
      pulse("dn55", 15, 55, 1'b0, 1'b0);
      pulse("dn32", 15, 32, 1'b0, 1'b0);
      pulse("dn10a", 15, 10, 1'b0, 1'b0);
      pulse("dn10b", 15, 10, 1'b0, 1'b0);
      pulse("dn10c", 15, 10, 1'b0, 1'b1);

      prox.distance = 20'd25;
      pulse("h13", 15, 13, 1'b1, 1'b1);
      pulse("h17", 15, 17, 1'b1, 1'b1);
      pulse("h21", 15, 21, 1'b1, 1'b1);
      pulse("h25", 15, 25, 1'b1, 1'b1);

      prox.distance = 20'd40;
      pulse("up28", 15, 28, 1'b1, 1'b1);
      pulse("up32", 15, 32, 1'b1, 1'b1);
      pulse("up36", 15, 36, 1'b1, 1'b1);
      pulse("up40", 15, 40, 1'b1, 1'b0);

      prox.distance = 20'd100;
      pulse("far55", 15, 55, 1'b0, 1'b0);
      pulse("far70", 15, 70, 1'b0, 1'b0);
      pulse("far85", 15, 85, 1'b0, 1'b0);
      pulse("far100", 15, 100, 1'b0, 1'b0);

      prox.distance = 20'd24;
      pulse("m81", 15, 81, 1'b0, 1'b0);
      pulse("m62", 15, 62, 1'b0, 1'b0);
      pulse("m43", 15, 43, 1'b0, 1'b0);
      pulse("m24", 15, 24, 1'b0, 1'b0);

      // single near vote, then a between-threshold average cancels it
      prox.distance = 20'd4;
      pulse("glitch19", 15, 19, 1'b0, 1'b0);
      prox.distance = 20'd40;
      pulse("cancel23", 15, 23, 1'b0, 1'b0);

      prox.distance = 20'd0;
      seen = 0;
      for (int i = 0; i < 79; i++) begin
         @(negedge clk);
         if (prox.sample_valid === 1'b1) seen++;
      end
      check("zero_pulses", seen, 0);
      check("zero_hold_avg", prox.avg_distance, 23);
      check("zero_near", {31'd0, prox.near}, 0);

      prox.distance = 20'd4;
      pulse("resume18", 16, 18, 1'b0, 1'b0);
      pulse("pend13", 15, 13, 1'b0, 1'b0);

      repeat (2) @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("midrst_avg", prox.avg_distance, 0);
      check("midrst_vld", {31'd0, prox.sample_valid}, 0);
      check("midrst_near", {31'd0, prox.near}, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      pulse("recover4", 67, 4, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
